// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared CHIP-8 memory constants and loader/receiver state encodings
package rom_loader_pkg;
    localparam int CHIP8_MEM_AW = 12;
    localparam logic [CHIP8_MEM_AW-1:0] CHIP8_PROG_BASE = 12'h200;
    localparam int CHIP8_MEM_SIZE = 4096;
    typedef enum logic [2:0] {HDR_HI, LEN_LO, DATA, DONE, ERROR} ld_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/rom_loader_uart_rx.sv
// uart_rx: 8N1 receiver with 2-flop synchronizer, mid-bit sampling and framing check
module uart_rx
    import rom_loader_pkg::*;
#(
    parameter int DIV = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);
    localparam int CW = $clog2(DIV);
    logic [2:0] sync;
    rx_state_t st;
    logic [CW-1:0] cnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic rxs, bit_tick, half_tick;
    // sync[1] is the synchronized line, sync[2] its previous value for edge detection
    assign rxs = sync[1];
    assign bit_tick = cnt == CW'(DIV - 1);
    assign half_tick = cnt == CW'(DIV / 2 - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 3'b111;
            st <= RX_IDLE;
            cnt <= '0;
            bit_idx <= '0;
            shreg <= '0;
            data <= '0;
            valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync <= {sync[1:0], rx};
            valid <= 1'b0;
            frame_err <= 1'b0;
            cnt <= cnt + CW'(1);
            case (st)
                RX_IDLE: begin
                    cnt <= '0;
                    if (sync[2] && !rxs) st <= RX_START;
                end
                RX_START: if (half_tick) begin
                    cnt <= '0;
                    bit_idx <= '0;
                    st <= rxs ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (bit_tick) begin
                    cnt <= '0;
                    shreg <= {rxs, shreg[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7) st <= RX_STOP;
                end
                RX_STOP: if (bit_tick) begin
                    st <= RX_IDLE;
                    valid <= rxs;
                    frame_err <= !rxs;
                    if (rxs) data <= shreg;
                end
                default: st <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/rom_loader.sv
// rom_loader: receives a length-prefixed CHIP-8 ROM over UART and writes it to memory
// while holding the cpu off the bus.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int CLK_HZ = 12_000_000,
    parameter int BAUD = 115_200,
    parameter logic [CHIP8_MEM_AW-1:0] LOAD_BASE = CHIP8_PROG_BASE,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    uart_rx,
    output logic                    mem_write,
    output logic [CHIP8_MEM_AW-1:0] mem_write_addr,
    output logic [7:0]              mem_write_data,
    output logic                    cpu_hold,
    output logic                    load_done,
    output logic                    load_error,
    output logic [CHIP8_MEM_AW-1:0] bytes_loaded
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int MAX_LEN = CHIP8_MEM_SIZE - int'(LOAD_BASE);
    localparam int TO_CYC = TIMEOUT_BITS * DIV;
    localparam int TW = $clog2(TO_CYC + 1);
    logic [7:0] rx_data;
    logic rx_valid, rx_ferr;
    ld_state_t state;
    logic [7:0] len_hi;
    logic [15:0] len, n_new;
    logic [CHIP8_MEM_AW-1:0] idx;
    logic [TW-1:0] tcnt;
    logic timed_out, counting;
    uart_rx #(.DIV(DIV)) u_rx (
        .clk(clk),
        .rst(rst),
        .rx(uart_rx),
        .data(rx_data),
        .valid(rx_valid),
        .frame_err(rx_ferr)
    );
    assign n_new = {len_hi, rx_data};
    assign counting = state == LEN_LO || state == DATA;
    assign timed_out = tcnt == TW'(TO_CYC - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HDR_HI;
            len_hi <= '0;
            len <= '0;
            idx <= '0;
            tcnt <= '0;
            mem_write <= 1'b0;
            mem_write_addr <= '0;
            mem_write_data <= '0;
            cpu_hold <= 1'b1;
            load_done <= 1'b0;
            load_error <= 1'b0;
            bytes_loaded <= '0;
        end else begin
            mem_write <= 1'b0;
            // status trails the state by one cycle so load_done follows the last write
            cpu_hold <= state != DONE;
            load_done <= state == DONE;
            load_error <= state == ERROR;
            tcnt <= (rx_valid || !counting) ? '0 : tcnt + TW'(1);
            case (state)
                HDR_HI: begin
                    if (rx_ferr) state <= ERROR;
                    else if (rx_valid) begin
                        len_hi <= rx_data;
                        state <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (rx_ferr) state <= ERROR;
                    else if (rx_valid) begin
                        len <= n_new;
                        idx <= '0;
                        state <= n_new == 16'd0 ? DONE : n_new > 16'(MAX_LEN) ? ERROR : DATA;
                    end else if (timed_out) state <= ERROR;
                end
                DATA: begin
                    if (rx_ferr) state <= ERROR;
                    else if (rx_valid) begin
                        mem_write <= 1'b1;
                        mem_write_addr <= LOAD_BASE + idx;
                        mem_write_data <= rx_data;
                        idx <= idx + 1'b1;
                        bytes_loaded <= bytes_loaded + 1'b1;
                        if ({4'd0, idx} + 16'd1 == len) state <= DONE;
                    end else if (timed_out) state <= ERROR;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: randomized UART frames against a queue-based write scoreboard
module tb_rom_loader;
    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD = 100_000;
    localparam int DIV = CLK_HZ / BAUD;
    // high load base keeps the full-memory boundary case within a short run
    localparam logic [11:0] LB = 12'hF80;
    localparam int MAXN = 4096 - int'(LB);

    logic clk = 1'b0, rst = 1'b1, uart_rx = 1'b1;
    logic mem_write, cpu_hold, load_done, load_error;
    logic [11:0] mem_write_addr, bytes_loaded;
    logic [7:0] mem_write_data;
    int checks = 0, errors = 0;
    logic [19:0] exp_q[$];
    logic prev_wr = 1'b0;

    rom_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .LOAD_BASE(LB), .TIMEOUT_BITS(64)) dut (
        .clk(clk),
        .rst(rst),
        .uart_rx(uart_rx),
        .mem_write(mem_write),
        .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data),
        .cpu_hold(cpu_hold),
        .load_done(load_done),
        .load_error(load_error),
        .bytes_loaded(bytes_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_write) begin
            chk("back_to_back_write", int'(prev_wr), 0);
            if (exp_q.size() == 0) chk("unexpected_write", int'({mem_write_addr, mem_write_data}), -1);
            else chk("write_addr_data", int'({mem_write_addr, mem_write_data}), int'(exp_q.pop_front()));
        end
        prev_wr = mem_write;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(posedge clk) uart_rx = 1'b0;
        repeat (DIV) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (DIV) @(posedge clk);
        end
        uart_rx = stop;
        repeat (DIV) @(posedge clk);
        uart_rx = 1'b1;
        repeat (DIV * $urandom_range(1, 3)) @(posedge clk);
    endtask

    // reference: payload byte i of a frame of length N lands at LB+i when 1 <= N <= MAXN
    task automatic send_frame(input int n, input logic [7:0] pl[$], input int nsend);
        logic [15:0] len = 16'(n);
        send_byte(len[15:8], 1'b1);
        send_byte(len[7:0], 1'b1);
        for (int i = 0; i < nsend; i++) begin
            if (n >= 1 && n <= MAXN && i < n) exp_q.push_back({LB + 12'(i), pl[i]});
            send_byte(pl[i], 1'b1);
        end
    endtask

    task automatic end_case(input string name, input int done, input int err, input int bl);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk({name, "_done"}, int'(load_done), done);
        chk({name, "_error"}, int'(load_error), err);
        chk({name, "_hold"}, int'(cpu_hold), int'(done == 0));
        chk({name, "_bytes"}, int'(bytes_loaded), bl);
        chk({name, "_missing_writes"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic rand_payload(input int n, output logic [7:0] pl[$]);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
    endtask

    initial begin
        logic [7:0] pl[$];
        int n, extra;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hold", int'(cpu_hold), 1);
        chk("rst_write", int'(mem_write), 0);
        chk("rst_done", int'(load_done), 0);
        chk("rst_error", int'(load_error), 0);
        rst = 1'b0;
        repeat (10000) @(posedge clk);
        end_case("idle", 0, 0, 0);

        pl = '{8'hA1, 8'hB2, 8'hC3};
        send_frame(3, pl, 3);
        end_case("basic", 1, 0, 3);

        for (int k = 0; k < 3; k++) begin
            do_reset();
            n = $urandom_range(1, 20);
            extra = $urandom_range(0, 2);
            rand_payload(n + extra, pl);
            send_frame(n, pl, n + extra);
            end_case("random", 1, 0, n);
        end

        do_reset();
        rand_payload(MAXN, pl);
        send_frame(MAXN, pl, MAXN);
        end_case("full", 1, 0, MAXN);
        do_reset();
        rand_payload(2, pl);
        send_frame(MAXN + 1, pl, 2);
        end_case("too_long", 0, 1, 0);

        do_reset();
        pl.delete();
        send_frame(0, pl, 0);
        end_case("zero_len", 1, 0, 0);
        send_byte(8'h55, 1'b1);
        end_case("after_done", 1, 0, 0);

        do_reset();
        pl = '{8'hA1};
        send_frame(2, pl, 1);
        repeat (600) @(posedge clk);
        @(negedge clk);
        chk("timeout_early", int'(load_error), 0);
        repeat (60) @(posedge clk);
        end_case("timeout", 0, 1, 1);

        do_reset();
        send_byte(8'h3C, 1'b0);
        end_case("framing", 0, 1, 0);

        do_reset();
        rand_payload(5, pl);
        send_frame(5, pl, 2);
        chk("abort_pending", exp_q.size(), 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_hold", int'(cpu_hold), 1);
        chk("abort_write", int'(mem_write), 0);
        chk("abort_bytes", int'(bytes_loaded), 0);
        chk("abort_done", int'(load_done), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        pl = '{8'h7E};
        send_frame(1, pl, 1);
        end_case("reload", 1, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
